// File: rtl/vec_mul_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vec_mul_pkg
//  Purpose  : Shared definitions for the vector-multiply sequencer: the FSM
//             state encoding and the default result-pipeline latency.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package vec_mul_pkg;

   // Cycles from UB address issue to the matching vec_mul result.
   localparam int PIPE_LATENCY_DEFAULT = 2;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD_W = 3'd1,
      RELOAD = 3'd2,
      STREAM = 3'd3,
      DRAIN  = 3'd4,
      DONE   = 3'd5
   } state_t;

endpackage : vec_mul_pkg
`default_nettype wire

// File: rtl/valid_delay_line.sv
`default_nettype none
// ============================================================================
//  Module   : valid_delay_line
//  Purpose  : Fixed-depth shift register that delays the address-issue strobe
//             until the matching result leaves the multiply pipeline.
//  Ports    : clk - clock, rising edge
//             rst - synchronous active-high reset (empties the line)
//             clr - synchronous clear (job abort), same effect as rst
//             d   - strobe in
//             q   - strobe out, DEPTH cycles after d
//  Params   : DEPTH - delay in cycles, must be >= 1
//  Revision : 1.0 - initial release
// ============================================================================
module valid_delay_line #(
   parameter int DEPTH = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic d,
   output logic q
);

   generate
      if (DEPTH == 1) begin : g_single
         logic r_stage;
         always_ff @(posedge clk) begin
            if (rst || clr) r_stage <= 1'b0;
            else            r_stage <= d;
         end
         assign q = r_stage;
      end else begin : g_chain
         logic [DEPTH-1:0] r_stage;
         always_ff @(posedge clk) begin
            if (rst || clr) r_stage <= '0;
            else            r_stage <= {r_stage[DEPTH-2:0], d};
         end
         assign q = r_stage[DEPTH-1];
      end
   endgenerate

endmodule : valid_delay_line
`default_nettype wire

// File: rtl/vec_mul_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : vec_mul_sequencer
//  Purpose  : Sequences one vector-multiply job: pop the weight FIFO, latch
//             the weights into the array, stream num_vec UB addresses, then
//             drain the result pipeline while writing result addresses.
//  Ports    : clk, rst                 - clock / synchronous active-high reset
//             start, abort             - job request / cancel
//             base_addr, num_vec       - job descriptor (latched on start)
//             busy                     - high whenever not IDLE
//             fifo_read_enable         - weight FIFO pop strobe
//             weight_reload            - systolic weight-latch strobe
//             sram_address             - UB read address (holds outside STREAM)
//             valid_address            - result-write strobe
//             sram_result_address      - result SRAM write address
//             end_                     - job-complete pulse
//             perf_cycles              - busy-cycle counter (optional)
//  Config   : VEC_MUL_SEQ_PERF_EN - when defined, adds perf_cycles
//  Revision : 1.0 - initial release
// ============================================================================
module vec_mul_sequencer
   import vec_mul_pkg::*;
#(
   parameter int ADDRESSSIZE  = 10,
   parameter int PIPE_LATENCY = PIPE_LATENCY_DEFAULT,
   parameter int PERF_BW      = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   abort,
   input  logic [ADDRESSSIZE-1:0] base_addr,
   input  logic [ADDRESSSIZE-1:0] num_vec,
   output logic                   busy,
   output logic                   fifo_read_enable,
   output logic                   weight_reload,
   output logic [ADDRESSSIZE-1:0] sram_address,
   output logic                   valid_address,
   output logic [ADDRESSSIZE-1:0] sram_result_address,
   output logic                   end_
`ifdef VEC_MUL_SEQ_PERF_EN
   ,
   output logic [PERF_BW-1:0]     perf_cycles
`endif
);

   // Drain counter only has to hold PIPE_LATENCY-1.
   localparam int DRAIN_W = (PIPE_LATENCY > 1) ? $clog2(PIPE_LATENCY) : 1;

   state_t                 r_state;
   logic [ADDRESSSIZE-1:0] r_base;
   logic [ADDRESSSIZE-1:0] r_cnt;     // remaining addresses after the current one
   logic [DRAIN_W-1:0]     r_drain;
   logic                   r_issue;   // high on every STREAM cycle

   // An abort while idle has nothing to cancel.
   logic w_kill;
   assign w_kill = abort && (r_state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state             <= IDLE;
         r_base              <= '0;
         r_cnt               <= '0;
         r_drain             <= '0;
         r_issue             <= 1'b0;
         busy                <= 1'b0;
         fifo_read_enable    <= 1'b0;
         weight_reload       <= 1'b0;
         end_                <= 1'b0;
         sram_address        <= '0;
         sram_result_address <= '0;
      end else begin
         fifo_read_enable <= 1'b0;
         weight_reload    <= 1'b0;
         end_             <= 1'b0;

         if (valid_address)
            sram_result_address <= sram_result_address + 1'b1;

         if (w_kill) begin
            r_state <= IDLE;
            r_issue <= 1'b0;
            busy    <= 1'b0;
         end else begin
            case (r_state)
               IDLE: begin
                  // abort in IDLE suppresses a simultaneous start
                  if (start && !abort) begin
                     sram_result_address <= '0;
                     busy                <= 1'b1;
                     if (num_vec != '0) begin
                        r_base           <= base_addr;
                        r_cnt            <= num_vec - 1'b1;
                        r_state          <= LOAD_W;
                        fifo_read_enable <= 1'b1;
                     end else begin
                        r_state <= DONE;
                        end_    <= 1'b1;
                     end
                  end
               end
               LOAD_W: begin
                  r_state       <= RELOAD;
                  weight_reload <= 1'b1;
               end
               RELOAD: begin
                  r_state      <= STREAM;
                  r_issue      <= 1'b1;
                  sram_address <= r_base;
               end
               STREAM: begin
                  if (r_cnt == '0) begin
                     r_state <= DRAIN;
                     r_issue <= 1'b0;
                     r_drain <= DRAIN_W'(PIPE_LATENCY - 1);
                  end else begin
                     sram_address <= sram_address + 1'b1;  // wraps mod 2^ADDRESSSIZE
                     r_cnt        <= r_cnt - 1'b1;
                  end
               end
               DRAIN: begin
                  if (r_drain == '0) begin
                     r_state <= DONE;
                     end_    <= 1'b1;
                  end else begin
                     r_drain <= r_drain - 1'b1;
                  end
               end
               DONE: begin
                  r_state <= IDLE;
                  busy    <= 1'b0;
               end
               default: begin
                  r_state <= IDLE;
                  r_issue <= 1'b0;
                  busy    <= 1'b0;
               end
            endcase
         end
      end
   end

   valid_delay_line #(
      .DEPTH (PIPE_LATENCY)
   ) u_valid_delay (
      .clk (clk),
      .rst (rst),
      .clr (w_kill),
      .d   (r_issue),
      .q   (valid_address)
   );

`ifdef VEC_MUL_SEQ_PERF_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_cycles <= '0;
      end else if (r_state == IDLE) begin
         if (start && !abort) perf_cycles <= '0;
      end else if (perf_cycles != '1) begin
         perf_cycles <= perf_cycles + 1'b1;
      end
   end
`else
   generate
      // Keeps PERF_BW referenced when the counter is compiled out.
      if (PERF_BW > 0) begin : g_perf_absent
      end
   endgenerate
`endif

endmodule : vec_mul_sequencer
`default_nettype wire

// File: tb/tb_vec_mul_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vec_mul_sequencer
//  Purpose  : Self-checking bench for vec_mul_sequencer. The driver turns each
//             job into a list of timed expected events (strobe, cycle, value);
//             a negedge monitor matches DUT outputs against that list.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vec_mul_sequencer;

   localparam int AW  = 10;
   localparam int LAT = 2;
   localparam int PBW = 16;

   localparam int K_FRE  = 0;
   localparam int K_REL  = 1;
   localparam int K_ADDR = 2;
   localparam int K_VAL  = 3;
   localparam int K_END  = 4;
   localparam int K_BUSY = 5;

   typedef struct {
      int kind;
      int cyc;
      int val;
   } ev_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic [AW-1:0] num_vec = '0;
   logic          busy, fifo_read_enable, weight_reload, valid_address, end_;
   logic [AW-1:0] sram_address, sram_result_address;
`ifdef VEC_MUL_SEQ_PERF_EN
   logic [PBW-1:0] perf_cycles;
`endif

   vec_mul_sequencer #(
      .ADDRESSSIZE  (AW),
      .PIPE_LATENCY (LAT),
      .PERF_BW      (PBW)
   ) dut (
      .clk                 (clk),
      .rst                 (rst),
      .start               (start),
      .abort               (abort),
      .base_addr           (base_addr),
      .num_vec             (num_vec),
      .busy                (busy),
      .fifo_read_enable    (fifo_read_enable),
      .weight_reload       (weight_reload),
      .sram_address        (sram_address),
      .valid_address       (valid_address),
      .sram_result_address (sram_result_address),
      .end_                (end_)
`ifdef VEC_MUL_SEQ_PERF_EN
      ,
      .perf_cycles         (perf_cycles)
`endif
   );

   always #5 clk = ~clk;

   int  cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int  n_checks = 0;
   int  n_fail   = 0;
   bit  mon_en   = 1'b0;
   int  exp_hold = 0;      // address sram_address must hold between jobs
   ev_t evq[$];
   ev_t mon_keep[$];

   task automatic check(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
      end
   endtask

   function automatic void push(input int k, input int c, input int v);
      ev_t e;
      e.kind = k;
      e.cyc  = c;
      e.val  = v;
      evq.push_back(e);
   endfunction

   // A cancelled job produces nothing after the cancelling cycle.
   function automatic void purge_after(input int c);
      ev_t tmp[$];
      foreach (evq[i]) if (evq[i].cyc <= c) tmp.push_back(evq[i]);
      evq = tmp;
   endfunction

   // ---------------------------------------------------------------- monitor
   always @(negedge clk) begin
      logic [5:0] e;
      int         v [6];
      if (mon_en) begin
         e = '0;
         for (int k = 0; k < 6; k++) v[k] = 0;
         foreach (evq[i]) begin
            if (evq[i].cyc == cyc) begin
               e[evq[i].kind] = 1'b1;
               v[evq[i].kind] = evq[i].val;
            end
         end
         if (fifo_read_enable || e[K_FRE]) check("fifo_read_enable", int'(fifo_read_enable), int'(e[K_FRE]));
         if (weight_reload || e[K_REL])    check("weight_reload", int'(weight_reload), int'(e[K_REL]));
         if (end_ || e[K_END])             check("end_", int'(end_), int'(e[K_END]));
         if (valid_address || e[K_VAL]) begin
            check("valid_address", int'(valid_address), int'(e[K_VAL]));
            if (valid_address && e[K_VAL])
               check("sram_result_address", int'(sram_result_address), v[K_VAL]);
         end
         if (e[K_ADDR]) check("sram_address", int'(sram_address), v[K_ADDR]);
         check("busy", int'(busy), int'(e[K_BUSY]));
         mon_keep.delete();
         foreach (evq[i]) if (evq[i].cyc > cyc) mon_keep.push_back(evq[i]);
         evq = mon_keep;
      end
   end

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"}, int'(busy), 0);
      check({tag, "_fifo_read_enable"}, int'(fifo_read_enable), 0);
      check({tag, "_weight_reload"}, int'(weight_reload), 0);
      check({tag, "_sram_address"}, int'(sram_address), 0);
      check({tag, "_valid_address"}, int'(valid_address), 0);
      check({tag, "_sram_result_address"}, int'(sram_result_address), 0);
      check({tag, "_end_"}, int'(end_), 0);
`ifdef VEC_MUL_SEQ_PERF_EN
      check({tag, "_perf_cycles"}, int'(perf_cycles), 0);
`endif
   endtask

   // ----------------------------------------------------------------- driver
   // Called at posedge+1; returns at posedge+1 of the first idle cycle.
   // kill_off/busy_off are cycle offsets from the start cycle (0 = none).
   task automatic run_job(input int b, input int n, input int kill_off,
                          input bit kill_rst, input int busy_off);
      int t, e_cyc, end_cyc, issued, last_iss;
      bit killed;
      t = cyc;
      start     = 1'b1;
      base_addr = AW'(b);
      num_vec   = AW'(n);
      if (n == 0) begin
         e_cyc = t + 1;
         push(K_BUSY, t + 1, 0);
         push(K_END, t + 1, 0);
      end else begin
         e_cyc = t + 3 + n + LAT;
         for (int c = t + 1; c <= e_cyc; c++) push(K_BUSY, c, 0);
         push(K_FRE, t + 1, 0);
         push(K_REL, t + 2, 0);
         for (int k = 0; k < n; k++) begin
            push(K_ADDR, t + 3 + k, (b + k) % 1024);
            push(K_VAL, t + 3 + k + LAT, k % 1024);
         end
         push(K_END, e_cyc, 0);
      end
      @(posedge clk); #1;
      start     = 1'b0;
      base_addr = AW'($urandom);
      num_vec   = AW'($urandom);
      killed  = 1'b0;
      end_cyc = e_cyc;
      for (int c = t + 1; c <= e_cyc; c++) begin
         if (c == t + busy_off) begin
            start     = 1'b1;
            base_addr = AW'($urandom);
            num_vec   = AW'($urandom);
         end
         if (c == t + kill_off) begin
            if (kill_rst) rst = 1'b1;
            else          abort = 1'b1;
            purge_after(c);
            killed  = 1'b1;
            end_cyc = c;
         end
         @(posedge clk); #1;
         start = 1'b0;
         abort = 1'b0;
         rst   = 1'b0;
         if (killed) break;
      end
      if (killed && kill_rst) begin
         exp_hold = 0;
         check_all_zero("post_rst");
      end else begin
         last_iss = (end_cyc < t + 2 + n) ? end_cyc : t + 2 + n;
         issued   = last_iss - (t + 2);
         if (n > 0 && issued > 0) exp_hold = (b + issued - 1) % 1024;
         check("sram_address_hold", int'(sram_address), exp_hold);
`ifdef VEC_MUL_SEQ_PERF_EN
         check("perf_cycles", int'(perf_cycles), end_cyc - t);
`endif
      end
   endtask

   task automatic idle_cycles(input int k);
      for (int i = 0; i < k; i++) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      int b, n, e_len, koff, boff;
      bit krst;
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst    = 1'b0;
      mon_en = 1'b1;
      idle_cycles(2);

      // nominal job, then a wrapping address run, then an empty job
      run_job(5, 4, 0, 1'b0, 0);
      idle_cycles(1);
      run_job(1022, 4, 0, 1'b0, 0);
      run_job(77, 0, 0, 1'b0, 0);
      idle_cycles(1);

      // abort on the 2nd STREAM cycle, followed straight away by a new job
      run_job(300, 6, 4, 1'b0, 0);
      run_job(40, 3, 0, 1'b0, 0);

      // start while streaming is ignored; rst in the first DRAIN cycle
      run_job(200, 5, 0, 1'b0, 4);
      run_job(100, 3, 3 + 3, 1'b1, 4);
      idle_cycles(1);

      // abort together with start while idle: no job
      start = 1'b1; abort = 1'b1; base_addr = 10'd9; num_vec = 10'd3;
      idle_cycles(1);
      start = 1'b0; abort = 1'b0;
      idle_cycles(2);

      for (int j = 0; j < 40; j++) begin
         b     = int'($urandom_range(0, 1023));
         n     = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 12));
         e_len = (n == 0) ? 1 : n + 3 + LAT;
         koff  = 0;
         krst  = 1'b0;
         case ($urandom_range(0, 11))
            0, 1, 2: koff = int'($urandom_range(1, e_len));
            3: begin koff = int'($urandom_range(1, e_len)); krst = 1'b1; end
            default: koff = 0;
         endcase
         boff = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, e_len)) : 0;
         run_job(b, n, koff, krst, boff);
         idle_cycles(int'($urandom_range(0, 2)));
      end

      idle_cycles(4);
      check("event_queue_drained", evq.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected completion", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule : tb_vec_mul_sequencer
`default_nettype wire

// File: doc/vec_mul_sequencer.md
VEC_MUL_SEQUENCER -- requirements
Module: vec_mul_sequencer

Interface
REQ-001 Parameters SHALL be:
- ADDRESSSIZE, 10, UB/result SRAM address width.
- PIPE_LATENCY, 2, cycles from UB address issue to vec_mul result valid.
- PERF_BW, 16, perf counter width.
REQ-002 Ports SHALL be:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle job request.
- abort  in  1  cancel the current job.
- base_addr  in  ADDRESSSIZE  first UB address of the job.
- num_vec  in  ADDRESSSIZE  number of input vectors in the job.
- busy  out  1  high in any state other than IDLE.
- fifo_read_enable  out  1  weight FIFO pop strobe.
- weight_reload  out  1  systolic weight-latch strobe.
- sram_address  out  ADDRESSSIZE  UB read address.
- valid_address  out  1  result-write strobe.
- sram_result_address  out  ADDRESSSIZE  result SRAM write address.
- end_  out  1  job-complete pulse.

Function
REQ-003 The FSM SHALL have exactly these states: IDLE, LOAD_W, RELOAD, STREAM, DRAIN, DONE.
REQ-004 In IDLE, start=1 with num_vec!=0 SHALL latch base_addr and num_vec, then enter LOAD_W on the next cycle.
REQ-005 In IDLE, start=1 with num_vec==0 SHALL go directly to DONE, with no FIFO pop, no reload and no address issue.
REQ-006 LOAD_W SHALL assert fifo_read_enable for exactly 1 cycle, then enter RELOAD.
REQ-007 RELOAD SHALL assert weight_reload for exactly 1 cycle, then enter STREAM.
REQ-008 STREAM SHALL issue one UB address per cycle, base_addr, base_addr+1, ..., for num_vec cycles, then enter DRAIN.
REQ-009 UB address arithmetic SHALL wrap modulo 2^ADDRESSSIZE.
REQ-010 An internal issue strobe SHALL be high on each STREAM cycle; valid_address SHALL equal that strobe delayed by exactly PIPE_LATENCY cycles through a shift register.
REQ-011 sram_result_address SHALL reset to 0 on job start and increment by 1, wrapping, on every cycle valid_address=1; the first result goes to address 0.
REQ-012 DRAIN SHALL last until the delay line is empty (PIPE_LATENCY cycles), then enter DONE.
REQ-013 DONE SHALL assert end_ for exactly 1 cycle, then return to IDLE.
REQ-014 start SHALL be ignored whenever busy=1.
REQ-015 abort=1 in any non-IDLE state SHALL go to IDLE on the next cycle: all strobes forced low, delay line cleared, no end_ pulse.
REQ-016 If abort and start are both high in IDLE, abort SHALL win and no job SHALL start.
REQ-017 sram_address SHALL hold its last value outside STREAM.

Reset
REQ-018 While rst=1, at the clock edge the block SHALL enter IDLE with every output 0 and the delay line cleared; rst mid-job SHALL behave like abort.

Configuration
REQ-019 Macro VEC_MUL_SEQ_PERF_EN:
- Defined: adds output perf_cycles [PERF_BW-1:0]; cleared on job start, increments on every non-IDLE cycle, saturates at all-ones, frozen in IDLE, reset to 0.
- Undefined: the port and its logic are absent.

Structure
REQ-020 A shared package vec_mul_pkg SHALL hold the FSM state encoding and the default PIPE_LATENCY constant.
REQ-021 The valid delay line SHALL be a sub-module named valid_delay_line, with parameter DEPTH and ports clk, rst, clr, d, q.

Verification
REQ-022 Nominal job: base_addr=5, num_vec=4, PIPE_LATENCY=2 -> fifo_read_enable at T+1, weight_reload at T+2, sram_address 5,6,7,8 at T+3..T+6, valid_address T+5..T+8 with result addresses 0..3, end_ at T+9.
REQ-023 Address wrap: base_addr=1022, num_vec=4 -> sram_address 1022, 1023, 0, 1.
REQ-024 Empty job: num_vec=0 -> end_ one cycle after start, no other strobes.
REQ-025 Abort: abort asserted on the 2nd STREAM cycle -> all strobes low on the next cycle, no end_, busy=0; a following start is accepted.
REQ-026 Busy start plus reset: start pulsed during STREAM -> ignored, one end_ only; rst asserted during DRAIN -> all outputs 0 next cycle.
REQ-027 With VEC_MUL_SEQ_PERF_EN defined and the REQ-022 job -> perf_cycles=9 after end_.
